picomem_arbiter_2_1: RTL and testbench
======================================

Name: picomem_arbiter_2_1

Overview:
Shares one PicoMem slave (e.g. a 4KB/16KB SRAM or the UART) between two PicoMem masters, typically the CPU (m0) and a DMA/debug master (m1).
Round-robin arbitration, one transaction in flight at a time.
A registered grant FSM gates slave valid and routes ready/rdata back to the granted master only.
A watchdog counter terminates transactions that the slave never acknowledges.

Parameters:
TIMEOUT_CYCLES, 256, cycles in GRANT without s_ready before forced completion; 0 disables the watchdog.
TIMEOUT_RDATA, 32'hDEADBEEF, rdata returned to the master on a timed-out transaction.
M0_FIRST, 1, initial priority after reset: 1 means m0, 0 means m1.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
m0_valid  in  1  master 0 request; held until m0_ready
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_wstrb  in  4  master 0 byte strobes; 0 means read
m0_ready  out  1  master 0 completion, single-cycle pulse
m0_rdata  out  32  master 0 read data, valid with m0_ready
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same widths and meaning as m0_*, for master 1
s_valid  out  1  slave request
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_wstrb  out  4  slave byte strobes
s_ready  in  1  slave completion
s_rdata  in  32  slave read data
grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle
timeout  out  1  one-cycle pulse when the watchdog terminates a transaction

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, prio=M0_FIRST, wd_cnt=0.
  - s_valid=0, m0_ready=0, m1_ready=0, grant=00, timeout=0.
  - m*_rdata and s_* address/data are don't-care but must not be X-propagating; drive 0.
- FSM states:
  - IDLE, GNT0, GNT1: all registered.
  - DONE: one-cycle bubble.
- IDLE:
  - Only one request: grant that master.
  - Both requests: grant the master indicated by prio.
  - Transition to GNTx takes effect on the next edge, so there is 1 cycle of arbitration latency.
- GNTx:
  - s_valid = mx_valid.
  - s_addr, s_wdata, s_wstrb = mx_* combinationally.
  - mx_ready = s_ready; mx_rdata = s_rdata.
  - The other master sees ready=0 and rdata=0.
- Completion in GNTx: s_ready=1 → DONE; prio := other master.
- DONE:
  - s_valid=0 and both readies=0.
  - Absorbs the cycle in which the master is still deasserting valid.
  - Next state is IDLE unconditionally.
  - Back-to-back fairness: alternating owners when both masters request continuously; 4 cycles minimum per transfer with a 1-cycle slave.
- Master drops valid while in GNTx without ready (protocol violation): s_valid follows it to 0; the FSM stays in GNTx until ready or timeout.
- Watchdog:
  - wd_cnt clears on entry to GNTx and increments each GNTx cycle with s_ready=0.
  - When wd_cnt == TIMEOUT_CYCLES-1 and s_ready=0:
    - s_valid is forced to 0 that cycle.
    - mx_ready=1 and mx_rdata=TIMEOUT_RDATA.
    - timeout=1.
    - Next state is DONE; prio rotates.
  - A timed-out write is dropped.
  - If s_ready and the terminal count coincide, s_ready wins: normal completion, timeout=0.
  - wd_cnt width is $clog2(TIMEOUT_CYCLES+1); with TIMEOUT_CYCLES=0 the counter is optimised out.
- s_ready while in IDLE or DONE is ignored; it is never forwarded to either master.
- Reset asserted mid-transaction aborts it immediately; the slave sees s_valid fall asynchronously.

Decomposition:
- Package picomem_pkg holds:
  - the state enum (IDLE, GNT0, GNT1, DONE);
  - the PICOMEM_ERR_RDATA constant (32'hDEADBEEF);
  - the GRANT_* one-hot codes.
- No sub-module is needed. The watchdog is small enough to stay inline. A 2-way rr picker is one expression.

Test Plan:
- Single read: m0 read addr 0x0000_0010, slave ready 1 cycle after s_valid with rdata 0x1234_5678 → m0_ready pulse, m0_rdata=0x12345678, grant=01 for 2 cycles, m1_ready stays 0.
- Simultaneous requests after reset, M0_FIRST=1, both held continuously → grants strictly m0, m1, m0, m1; each m*_ready seen exactly once per grant.
- Write routing: m1 write wstrb=4'b0011, wdata=0xAABB_CCDD, addr 0x4000_0004 → s_wstrb=0011, s_wdata=AABBCCDD, s_addr=40000004 while grant=10; m0 sees ready=0.
- Watchdog: TIMEOUT_CYCLES=8, slave never asserts ready → on the 8th GNT cycle m0_ready=1, m0_rdata=DEADBEEF, timeout=1 for 1 cycle, then IDLE and the next request served normally.
- Tie case: s_ready coincides with the terminal watchdog count → slave rdata returned, timeout=0.
- Async reset during GNT1 with s_valid=1 → s_valid, m1_ready and grant drop without a clk edge; after release prio=m0 and a pending m0 request is granted first.

Source files
------------

// File: rtl/picomem_pkg.sv
// Shared types and constants for the PicoMem 2:1 arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package picomem_pkg;

    // Arbiter FSM states: idle, granted to m0, granted to m1, one-cycle bubble.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Read data returned to a master whose transaction was killed by the watchdog.
    localparam logic [31:0] PICOMEM_ERR_RDATA = 32'hDEADBEEF;

    // One-hot owner codes presented on the grant output.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/picomem_arbiter_2_1.sv
// Round-robin 2:1 PicoMem arbiter with a per-transaction watchdog.
// Latency: 1 cycle arbitration, slave latency passed through, 1 bubble cycle after completion.
// Backpressure: non-granted master waits with ready=0; a stalled slave is cut off after TIMEOUT_CYCLES.
module picomem_arbiter_2_1
    import picomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = PICOMEM_ERR_RDATA,
    parameter bit          M0_FIRST       = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    state_e state_q, state_d;
    // prio_q = 0: m0 wins a tie; prio_q = 1: m1 wins a tie.
    logic   prio_q, prio_d;
    logic   gnt0, gnt1, in_gnt;
    logic   wd_term;

    assign gnt0   = (state_q == ST_GNT0);
    assign gnt1   = (state_q == ST_GNT1);
    assign in_gnt = gnt0 | gnt1;

    // Grant decodes straight from the state flop, so it is glitch-free and drops with reset.
    assign grant   = {gnt1, gnt0};
    assign timeout = wd_term;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

            logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

            // Count stalled grant cycles; held at zero outside a grant so every grant starts fresh.
            always_comb begin
                wd_cnt_d = wd_cnt_q;
                if (!in_gnt) begin
                    wd_cnt_d = '0;
                end else if (!s_ready) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end

            // Watchdog counter register.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wd_cnt_q <= '0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                end
            end

            // A coincident s_ready takes precedence over the terminal count.
            assign wd_term = in_gnt & ~s_ready & (wd_cnt_q == WD_LAST);
        end else begin : g_no_wd
            assign wd_term = 1'b0;
        end
    endgenerate

    // Route the granted master to the slave and the slave response back to that master only.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        if (gnt0) begin
            s_valid  = m0_valid & ~wd_term;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = s_ready | wd_term;
            m0_rdata = wd_term ? TIMEOUT_RDATA : s_rdata;
        end else if (gnt1) begin
            s_valid  = m1_valid & ~wd_term;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = s_ready | wd_term;
            m1_rdata = wd_term ? TIMEOUT_RDATA : s_rdata;
        end
    end

    // Next-state and round-robin priority; priority rotates only when a grant completes.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && (!m1_valid || !prio_q)) begin
                    state_d = ST_GNT0;
                end else if (m1_valid) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (s_ready || wd_term) begin
                    state_d = ST_DONE;
                    prio_d  = 1'b1;
                end
            end
            ST_GNT1: begin
                if (s_ready || wd_term) begin
                    state_d = ST_DONE;
                    prio_d  = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and priority registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            prio_q  <= ~M0_FIRST;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Randomized bench for picomem_arbiter_2_1 against a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: random slave latency including ties with and overruns of the watchdog.
module tb_picomem_arbiter_2_1;

    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_valid, s_ready, timeout;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    picomem_arbiter_2_1 #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (ERR),
        .M0_FIRST      (1'b1)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid (s_valid),  .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready (s_ready),  .s_rdata(s_rdata),
        .grant   (grant),
        .timeout (timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Master agents: one outstanding transaction each.
    logic        pend [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic [3:0]  t_wstrb [2];
    int          gap [2];
    logic        no_new;

    // Slave agent.
    logic [31:0] slv_mem [16];
    int          lat, s_cnt;
    logic [1:0]  prev_g;

    // Reference model: owner (-1 none), tie priority, bubble flag, cycles into grant, memory.
    int          own;
    logic        mprio;
    logic        bubble;
    int          mcnt;
    logic [31:0] ref_mem [16];

    task automatic drive_masters();
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && !no_new) begin
                if (gap[i] > 0) gap[i]--;
                else if ($urandom_range(0, 1) == 1) begin
                    pend[i]    = 1'b1;
                    t_addr[i]  = 32'($urandom_range(0, 15)) << 2;
                    t_wdata[i] = $urandom;
                    t_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                end
            end
        end
        m0_valid = pend[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0]; m0_wstrb = t_wstrb[0];
        m1_valid = pend[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1]; m1_wstrb = t_wstrb[1];
    endtask

    task automatic slave_step();
        int r;
        if (grant != 2'b00) begin
            if (prev_g == 2'b00) begin
                s_cnt = 0;
                r = $urandom_range(0, 9);
                if (r < 6)       lat = $urandom_range(0, 3);
                else if (r < 8)  lat = TO - 1;
                else if (r == 8) lat = TO - 2;
                else             lat = 20;
            end else begin
                s_cnt++;
            end
            s_ready = (s_cnt == lat);
        end else begin
            s_ready = ($urandom_range(0, 1) == 1);
        end
        s_rdata = (s_ready && grant != 2'b00 && s_wstrb == 4'h0) ? slv_mem[s_addr[5:2]] : $urandom;
        prev_g = grant;
    endtask

    task automatic observe();
        logic        fin, tmo;
        logic [1:0]  eg;
        logic [31:0] orr, er;
        fin = 1'b0;
        tmo = 1'b0;
        if (own >= 0) begin
            fin = (mcnt == lat);
            tmo = !fin && (mcnt == TO - 1);
        end
        eg = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("m0_ready", 32'(m0_ready), 32'(own == 0 && (fin || tmo)));
        check_eq("m1_ready", 32'(m1_ready), 32'(own == 1 && (fin || tmo)));
        check_eq("timeout", 32'(timeout), 32'(tmo));
        check_eq("s_valid", 32'(s_valid), 32'(own >= 0 && !tmo));
        if (own != 0) check_eq("m0_rdata_idle", m0_rdata, 32'h0);
        if (own != 1) check_eq("m1_rdata_idle", m1_rdata, 32'h0);
        if (own >= 0) begin
            orr = (own == 0) ? m0_rdata : m1_rdata;
            if (fin) begin
                check_eq("s_addr", s_addr, t_addr[own]);
                check_eq("s_wdata", s_wdata, t_wdata[own]);
                check_eq("s_wstrb", 32'(s_wstrb), 32'(t_wstrb[own]));
                er = (t_wstrb[own] == 4'h0) ? ref_mem[t_addr[own][5:2]] : s_rdata;
                check_eq("rdata", orr, er);
                if (t_wstrb[own] != 4'h0)
                    ref_mem[t_addr[own][5:2]] = merge(ref_mem[t_addr[own][5:2]], t_wdata[own], t_wstrb[own]);
            end
            if (tmo) check_eq("rdata_timeout", orr, ERR);
        end
        if (s_ready && grant != 2'b00 && s_wstrb != 4'h0)
            slv_mem[s_addr[5:2]] = merge(slv_mem[s_addr[5:2]], s_wdata, s_wstrb);
        // Model update: completion frees the owner and leaves one bubble cycle before arbitration.
        if (own >= 0) begin
            if (fin || tmo) begin
                mprio     = (own == 0);
                pend[own] = 1'b0;
                gap[own]  = $urandom_range(0, 2);
                own       = -1;
                bubble    = 1'b1;
            end else begin
                mcnt++;
            end
        end else if (bubble) begin
            bubble = 1'b0;
        end else if (pend[0] || pend[1]) begin
            own  = (pend[0] && pend[1]) ? (mprio ? 1 : 0) : (pend[0] ? 0 : 1);
            mcnt = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_masters();
        #1 slave_step();
        #1 observe();
    endtask

    task automatic wait_grant(input logic [1:0] g);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (grant == g) return;
        end
        check_eq("wait_grant", 32'(grant), 32'(g));
    endtask

    initial begin
        resetn = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        pend[0] = 1'b0; pend[1] = 1'b0; gap[0] = 0; gap[1] = 0;
        t_addr[0] = 0; t_addr[1] = 0; t_wdata[0] = 0; t_wdata[1] = 0;
        t_wstrb[0] = 0; t_wstrb[1] = 0;
        no_new = 1'b0; lat = 0; s_cnt = 0; prev_g = 2'b00;
        own = -1; mprio = 1'b0; bubble = 1'b0; mcnt = 0;

        // Reset state with requests and slave ready asserted.
        #2;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_s_valid", 32'(s_valid), 32'h0);
        check_eq("rst_m0_ready", 32'(m0_ready), 32'h0);
        check_eq("rst_m1_ready", 32'(m1_ready), 32'h0);
        check_eq("rst_timeout", 32'(timeout), 32'h0);
        check_eq("rst_m0_rdata", m0_rdata, 32'h0);
        check_eq("rst_s_addr", s_addr, 32'h0);

        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) cycle();

        // Drain outstanding transactions.
        no_new = 1'b1;
        for (int i = 0; i < 300 && (pend[0] || pend[1] || own >= 0); i++) cycle();
        check_eq("drain", 32'(pend[0] || pend[1] || own >= 0), 32'h0);

        // Directed single read by m0, slave answers one cycle after s_valid.
        @(negedge clk);
        s_ready = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0; m1_valid = 1'b0;
        wait_grant(2'b01);
        check_eq("rd_s_valid", 32'(s_valid), 32'h1);
        check_eq("rd_s_addr", s_addr, 32'h0000_0010);
        check_eq("rd_wait_ready", 32'(m0_ready), 32'h0);
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        check_eq("rd_m0_ready", 32'(m0_ready), 32'h1);
        check_eq("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        check_eq("rd_m1_ready", 32'(m1_ready), 32'h0);
        check_eq("rd_grant", 32'(grant), 32'h1);
        @(negedge clk);
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        check_eq("done_grant", 32'(grant), 32'h0);
        check_eq("done_m0_ready", 32'(m0_ready), 32'h0);

        // Directed m1 write, then async reset while it is granted.
        m1_valid = 1'b1; m1_addr = 32'h4000_0004; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
        wait_grant(2'b10);
        check_eq("wr_s_valid", 32'(s_valid), 32'h1);
        check_eq("wr_s_addr", s_addr, 32'h4000_0004);
        check_eq("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
        check_eq("wr_s_wstrb", 32'(s_wstrb), 32'h3);
        check_eq("wr_m0_ready", 32'(m0_ready), 32'h0);
        #1 resetn = 1'b0;
        #1;
        check_eq("arst_s_valid", 32'(s_valid), 32'h0);
        check_eq("arst_m1_ready", 32'(m1_ready), 32'h0);
        check_eq("arst_grant", 32'(grant), 32'h0);
        m0_valid = 1'b1; m0_addr = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check_eq("arst_prio_m0", 32'(grant), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
